// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with round-robin grant.
// Latency: the request is accepted at edge T and the ALU inputs are registered at that edge.
//          The result is captured at edge T+1 and rsp_valid is held until the consumer takes it.
// Backpressure: while rsp_ready is low the response holds stable and both request readys stay low.
// Optional feature: define ALU_ARB_OPCHECK_EN to flag opcodes 101-111 as illegal.
//                   Such a request still completes, but with rsp_err set.
module alu_arbiter #(
   parameter int N     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [N-1:0]     req0_a,
   input  logic [N-1:0]     req0_b,
   input  logic [2:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [N-1:0]     req1_a,
   input  logic [N-1:0]     req1_b,
   input  logic [2:0]       req1_op,
   output logic [N-1:0]     alu_a,
   output logic [N-1:0]     alu_b,
   output logic [2:0]       alu_op,
   input  logic [N-1:0]     alu_c,
   input  logic             alu_ov,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [N-1:0]     rsp_c,
   output logic             rsp_ov,
   output logic             rsp_err,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_last_grant;
   logic [N-1:0]     r_alu_a;
   logic [N-1:0]     r_alu_b;
   logic [2:0]       r_alu_op;
   logic             r_rsp_valid;
   logic             r_rsp_id;
   logic [N-1:0]     r_rsp_c;
   logic             r_rsp_ov;
   logic [CNT_W-1:0] r_op_count;

   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_accept;
   logic             w_rsp_done;
   logic [N-1:0]     w_a_sel;
   logic [N-1:0]     w_b_sel;
   logic [2:0]       w_op_sel;
   logic             w_illegal;
   logic             w_err_pend;

   assign w_accept   = w_gnt0 | w_gnt1;
   assign w_rsp_done = (r_state == S_RESP) && r_rsp_valid && rsp_ready;
   assign w_a_sel    = w_gnt1 ? req1_a  : req0_a;
   assign w_b_sel    = w_gnt1 ? req1_b  : req0_b;
   assign w_op_sel   = w_gnt1 ? req1_op : req0_op;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and grant; the requester that did not win last time wins a tie
   always_comb begin
      w_state_nxt = r_state;
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (rst_n) begin
               w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
               w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
            end
            if (w_gnt0 || w_gnt1) begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            if (w_rsp_done) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Launch operands on accept, capture the result one cycle later, retire on response handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_op     <= 3'b000;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_c      <= '0;
         r_rsp_ov     <= 1'b0;
         r_op_count   <= '0;
      end else begin
         if (w_accept) begin
            r_alu_a      <= w_illegal ? '0 : w_a_sel;
            r_alu_b      <= w_illegal ? '0 : w_b_sel;
            r_alu_op     <= w_illegal ? 3'b000 : w_op_sel;
            r_rsp_id     <= w_gnt1;
            r_last_grant <= w_gnt1;
         end
         if (r_state == S_EXEC) begin
            r_rsp_c     <= w_err_pend ? '0 : alu_c;
            r_rsp_ov    <= alu_ov & ~w_err_pend;
            r_rsp_valid <= 1'b1;
         end
         if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
            if (r_op_count != '1) begin
               r_op_count <= r_op_count + CNT_W'(1);
            end
         end
      end
   end

`ifdef ALU_ARB_OPCHECK_EN
   logic r_err_pend;
   logic r_rsp_err;

   assign w_illegal  = (w_op_sel >= 3'd5);
   assign w_err_pend = r_err_pend;
   assign rsp_err    = r_rsp_err;

   // Remember illegality from accept until capture, then present it with the response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_pend <= 1'b0;
         r_rsp_err  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_err_pend <= w_illegal;
         end
         if (r_state == S_EXEC) begin
            r_rsp_err <= r_err_pend;
         end
      end
   end
`else
   assign w_illegal  = 1'b0;
   assign w_err_pend = 1'b0;
   assign rsp_err    = 1'b0;
`endif

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_op     = r_alu_op;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_c      = r_rsp_c;
   assign rsp_ov     = r_rsp_ov;
   assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed transactions, a transaction-level model compared every cycle,
// and hand-computed literal expectations at the key points. CNT_W is 2 to exercise saturation.
module tb_alu_arbiter;

   localparam int N     = 32;
   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req1_valid;
   logic             req0_ready, req1_ready;
   logic [N-1:0]     req0_a, req0_b, req1_a, req1_b;
   logic [2:0]       req0_op, req1_op;
   logic [N-1:0]     alu_a, alu_b, alu_c;
   logic [2:0]       alu_op;
   logic             alu_ov;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_ov, rsp_err;
   logic [N-1:0]     rsp_c;
   logic [CNT_W-1:0] op_count;

   int checks = 0;
   int passes = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   alu_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_c(alu_c), .alu_ov(alu_ov),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_c(rsp_c), .rsp_ov(rsp_ov), .rsp_err(rsp_err),
      .op_count(op_count)
   );

   // Stand-in for the attached ALU: returns {overflow, result}
   function automatic logic [N:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [2:0] op);
      logic [N-1:0] c;
      logic         ov;
      ov = 1'b0;
      case (op)
         3'd0: begin c = a + b; ov = (a[N-1] == b[N-1]) && (c[N-1] != a[N-1]); end
         3'd1: begin c = a - b; ov = (a[N-1] != b[N-1]) && (c[N-1] != a[N-1]); end
         3'd2: c = a & b;
         3'd3: c = a | b;
         3'd4: c = a ^ b;
         3'd5: c = a << b[4:0];
         3'd6: c = a >> b[4:0];
         default: c = ~a;
      endcase
      return {ov, c};
   endfunction

   assign {alu_ov, alu_c} = alu_fn(alu_a, alu_b, alu_op);

   function automatic bit op_illegal(input logic [2:0] op);
`ifdef ALU_ARB_OPCHECK_EN
      return op >= 3'd5;
`else
      return (op != op);
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Transaction-level model: one job in flight, result offered one cycle after accept
   bit           m_busy = 1'b0;
   int           m_age  = 0;
   bit           m_last = 1'b1;
   bit           m_id   = 1'b0;
   logic [N-1:0] m_c    = '0;
   bit           m_ov   = 1'b0;
   bit           m_err  = 1'b0;
   int           m_cnt  = 0;
   logic [N-1:0] m_a    = '0;
   logic [N-1:0] m_b    = '0;
   logic [2:0]   m_op   = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_age <= 0; m_last <= 1'b1; m_cnt <= 0;
         m_a <= '0; m_b <= '0; m_op <= '0;
      end else if (!m_busy) begin
         if (req0_valid || req1_valid) begin
            bit           k;
            logic [N-1:0] a, b;
            logic [2:0]   op;
            logic [N:0]   r;
            k  = (req0_valid && (!req1_valid || m_last)) ? 1'b0 : 1'b1;
            a  = k ? req1_a : req0_a;
            b  = k ? req1_b : req0_b;
            op = k ? req1_op : req0_op;
            r  = alu_fn(a, b, op);
            m_busy <= 1'b1; m_age <= 0; m_last <= k; m_id <= k;
            if (op_illegal(op)) begin
               m_a <= '0; m_b <= '0; m_op <= '0;
               m_c <= '0; m_ov <= 1'b0; m_err <= 1'b1;
            end else begin
               m_a <= a; m_b <= b; m_op <= op;
               m_c <= r[N-1:0]; m_ov <= r[N]; m_err <= 1'b0;
            end
         end
      end else if (m_age >= 1 && rsp_ready) begin
         m_busy <= 1'b0;
         if (m_cnt < CMAX) m_cnt <= m_cnt + 1;
      end else begin
         m_age <= m_age + 1;
      end
   end

   // Compare every output against the model on each falling edge
   always @(negedge clk) begin
      if (cmp_en) begin
         bit e_r0, e_r1, e_v;
         e_r0 = rst_n && !m_busy && req0_valid && (!req1_valid || m_last);
         e_r1 = rst_n && !m_busy && req1_valid && (!req0_valid || !m_last);
         e_v  = m_busy && (m_age >= 1);
         chk("req0_ready", 64'(req0_ready), 64'(e_r0));
         chk("req1_ready", 64'(req1_ready), 64'(e_r1));
         chk("rsp_valid", 64'(rsp_valid), 64'(e_v));
         chk("op_count", 64'(op_count), 64'(m_cnt));
         chk("alu_a", 64'(alu_a), 64'(m_a));
         chk("alu_b", 64'(alu_b), 64'(m_b));
         chk("alu_op", 64'(alu_op), 64'(m_op));
         if (e_v) begin
            chk("rsp_id", 64'(rsp_id), 64'(m_id));
            chk("rsp_c", 64'(rsp_c), 64'(m_c));
            chk("rsp_ov", 64'(rsp_ov), 64'(m_ov));
            chk("rsp_err", 64'(rsp_err), 64'(m_err));
         end
      end
   end

   task automatic step(); @(posedge clk); #1; endtask
   task automatic smp();  @(negedge clk);     endtask

   // Present one request and drop valid right after the accepting edge
   task automatic send(input bit k, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2:0] op);
      bit done;
      done = 1'b0;
      step();
      if (!k) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
      else    begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
      for (int i = 0; i < 20 && !done; i++) begin
         smp();
         if (k ? req1_ready : req0_ready) done = 1'b1;
         step();
      end
      if (!k) req0_valid = 1'b0; else req1_valid = 1'b0;
      chk("send_accepted", 64'(done), 64'd1);
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         smp();
         if (!m_busy) done = 1'b1; else step();
      end
      chk("wait_idle", 64'(done), 64'd1);
   endtask

   task automatic reset_pulse();
      step(); rst_n = 1'b0;
      step(); rst_n = 1'b1;
   endtask

   logic [N-1:0] va[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_F0F0, 32'd5, 32'h0000_000A};
   logic [N-1:0] vb[5] = '{32'd1, 32'd1, 32'h0000_0FF0, 32'd7, 32'd3};
   logic [2:0]   vo[5] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd4};
   logic [N-1:0] vc[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_00F0, 32'hFFFF_FFFE, 32'd9};
   logic         vv[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   int           vn[5] = '{1, 2, 3, 3, 3};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
      #1 rst_n = 1'b0;
      #2 cmp_en = 1'b1;

      // Reset: outputs at reset values and no ready even with a valid present
      req0_valid = 1'b1;
      smp();
      chk("rst_req0_ready", 64'(req0_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_op_count", 64'(op_count), 64'd0);
      chk("rst_alu_a", 64'(alu_a), 64'd0);
      req0_valid = 1'b0;
      step(); rst_n = 1'b1;

      // Single add from requester 0; the request is presented in the cycle after edge T
      send(1'b0, 32'd345, 32'd234, 3'b000);
      smp();
      chk("t1_exec_no_rsp", 64'(rsp_valid), 64'd0);
      chk("t1_alu_a", 64'(alu_a), 64'd345);
      step(); smp();
      chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("t1_rsp_c", 64'(rsp_c), 64'd579);
      chk("t1_rsp_id", 64'(rsp_id), 64'd0);
      chk("t1_rsp_ov", 64'(rsp_ov), 64'd0);
      step(); smp();
      chk("t1_op_count", 64'(op_count), 64'd1);

      // Contention right after reset: requester 0 first, then the held requester 1
      reset_pulse();
      step();
      req0_valid = 1'b1; req0_a = 32'd672; req0_b = 32'd85;  req0_op = 3'b001;
      req1_valid = 1'b1; req1_a = 32'd213; req1_b = 32'd345; req1_op = 3'b000;
      smp();
      chk("t2_grant0", 64'({req0_ready, req1_ready}), 64'b10);
      step(); req0_valid = 1'b0;
      smp(); step(); smp();
      chk("t2_rsp0_c", 64'(rsp_c), 64'd587);
      chk("t2_rsp0_id", 64'(rsp_id), 64'd0);
      step(); smp();
      chk("t2_held_grant1", 64'(req1_ready), 64'd1);
      step(); req1_valid = 1'b0;
      smp(); step(); smp();
      chk("t2_rsp1_c", 64'(rsp_c), 64'd558);
      chk("t2_rsp1_id", 64'(rsp_id), 64'd1);
      step();
      req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_op = 3'b010;
      req1_valid = 1'b1; req1_a = 32'd30; req1_b = 32'd40; req1_op = 3'b011;
      smp();
      chk("t2_next_grant0", 64'({req0_ready, req1_ready}), 64'b10);
      step(); req0_valid = 1'b0;
      smp(); step(); smp(); step(); smp();
      chk("t2_then_grant1", 64'(req1_ready), 64'd1);
      step(); req1_valid = 1'b0;
      wait_idle();

      // Backpressure: response held, no second accept while blocked
      step(); rsp_ready = 1'b0;
      send(1'b0, 32'd100, 32'd23, 3'b000);
      req1_valid = 1'b1; req1_a = 32'd5; req1_b = 32'd6; req1_op = 3'b001;
      smp(); step(); smp();
      chk("t3_rsp_valid", 64'(rsp_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         step(); smp();
         chk("t3_hold_c", 64'(rsp_c), 64'd123);
         chk("t3_hold_valid", 64'(rsp_valid), 64'd1);
         chk("t3_no_accept", 64'(req1_ready), 64'd0);
      end
      step(); rsp_ready = 1'b1;
      smp(); step(); smp();
      chk("t3_released", 64'(rsp_valid), 64'd0);
      chk("t3_idle_grant1", 64'(req1_ready), 64'd1);
      step(); req1_valid = 1'b0;
      wait_idle();

      // Asynchronous reset during EXEC drops the job
      reset_pulse();
      send(1'b0, 32'd1, 32'd2, 3'b000);
      rst_n = 1'b0;
      smp();
      chk("t4_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("t4_op_count", 64'(op_count), 64'd0);
      chk("t4_alu_a", 64'(alu_a), 64'd0);
      step(); step(); rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         smp();
         chk("t4_no_rsp", 64'(rsp_valid), 64'd0);
         step();
      end

      // Opcode 110: illegal with the check enabled, plain shift otherwise
      send(1'b0, 32'h1234_0000, 32'd4, 3'b110);
      smp();
`ifdef ALU_ARB_OPCHECK_EN
      chk("t5_alu_op", 64'(alu_op), 64'd0);
      chk("t5_alu_a", 64'(alu_a), 64'd0);
`else
      chk("t5_alu_op", 64'(alu_op), 64'd6);
      chk("t5_alu_a", 64'(alu_a), 64'h1234_0000);
`endif
      step(); smp();
`ifdef ALU_ARB_OPCHECK_EN
      chk("t5_rsp_err", 64'(rsp_err), 64'd1);
      chk("t5_rsp_c", 64'(rsp_c), 64'd0);
`else
      chk("t5_rsp_err", 64'(rsp_err), 64'd0);
      chk("t5_rsp_c", 64'(rsp_c), 64'h0123_4000);
`endif
      wait_idle();

      // Five completions from zero: counter saturates at 3 with CNT_W = 2
      reset_pulse();
      for (int i = 0; i < 5; i++) begin
         send(1'(i % 2), va[i], vb[i], vo[i]);
         smp(); step(); smp();
         chk("t6_rsp_c", 64'(rsp_c), 64'(vc[i]));
         chk("t6_rsp_ov", 64'(rsp_ov), 64'(vv[i]));
         chk("t6_rsp_id", 64'(rsp_id), 64'(i % 2));
         step(); smp();
         chk("t6_op_count", 64'(op_count), 64'(vn[i]));
      end

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
